cmip_fifo_burst_reader: RTL and testbench

CMIP_FIFO_BURST_READER -- requirements
Module: cmip_fifo_burst_reader

---
 rtl/cmip_pkg.sv | 17 +
 rtl/cmip_skid_buf.sv | 54 +++++
 rtl/cmip_fifo_burst_reader.sv | 154 +++++++++++++++
 tb/tb_cmip_fifo_burst_reader.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmip_pkg.sv
// Shared definitions for the CMIP FIFO burst reader.
//   burst_state_e : reader FSM state encoding
//   SKID_DPTH     : entries in the output skid buffer
//   SKID_CNT_WDTH : width of the skid occupancy count (0..SKID_DPTH)
//   TOUT_WDTH     : width of the partial-burst timeout threshold/counter
package cmip_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } burst_state_e;

  localparam int unsigned SKID_DPTH     = 2;
  localparam int unsigned SKID_CNT_WDTH = 2;
  localparam int unsigned TOUT_WDTH     = 16;

endpackage

// File: rtl/cmip_skid_buf.sv
// Two-entry skid FIFO between the upstream pop and the downstream stream.
//   i_push/i_wdata : write one entry (caller guarantees room)
//   i_ready        : downstream ready; a pop happens on o_valid & i_ready
//   o_valid        : buffer not empty
//   o_rdata        : head entry
//   o_cnt          : current occupancy
module cmip_skid_buf
  import cmip_pkg::*;
#(
  parameter int unsigned WDTH = 33
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WDTH-1:0]          i_wdata,
  input  logic                     i_ready,
  output logic                     o_valid,
  output logic [WDTH-1:0]          o_rdata,
  output logic [SKID_CNT_WDTH-1:0] o_cnt
);

  logic [WDTH-1:0]          mem_q [SKID_DPTH];
  logic                     rd_ptr_q;
  logic                     wr_ptr_q;
  logic [SKID_CNT_WDTH-1:0] cnt_q;
  logic                     pop;

  assign o_valid = (cnt_q != '0);
  assign pop     = o_valid && i_ready;
  assign o_rdata = mem_q[rd_ptr_q];
  assign o_cnt   = cnt_q;

  // Storage, pointers and occupancy; push+pop together keeps the count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < SKID_DPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (i_push) begin
        mem_q[wr_ptr_q] <= i_wdata;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({i_push, pop})
        2'b10:   cnt_q <= cnt_q + SKID_CNT_WDTH'(1);
        2'b01:   cnt_q <= cnt_q - SKID_CNT_WDTH'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/cmip_fifo_burst_reader.sv
// Reads fixed-length bursts out of an upstream FWFT FIFO and streams them
// downstream through a 2-entry skid buffer, tagging the final beat.
// Optional partial-burst timeout flush: define CMIP_BURST_RD_TOUT_EN.
//   i_burst_len      : beats per burst (0 -> 1, clipped to DPTH)
//   i_tout_th        : timeout in cycles, 0 disables (timeout build only)
//   i_fifo_empty/i_fifo_dout/i_fifo_used_cnt/o_fifo_rd : upstream FIFO
//   o_valid/o_data/o_last/i_ready : downstream stream
//   o_busy           : burst in progress or skid holds data
//   o_burst_cnt      : completed bursts, wraps
//   o_tout_flush     : pulse when a timeout-triggered burst starts
module cmip_fifo_burst_reader
  import cmip_pkg::*;
#(
  parameter int unsigned DATA_WDTH = 32,
  parameter int unsigned ADDR_WDTH = 3,
  parameter int unsigned DPTH      = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [ADDR_WDTH:0]   i_burst_len,
  input  logic [TOUT_WDTH-1:0] i_tout_th,
  input  logic                 i_fifo_empty,
  input  logic [DATA_WDTH-1:0] i_fifo_dout,
  input  logic [ADDR_WDTH:0]   i_fifo_used_cnt,
  output logic                 o_fifo_rd,
  output logic                 o_valid,
  output logic [DATA_WDTH-1:0] o_data,
  output logic                 o_last,
  input  logic                 i_ready,
  output logic                 o_busy,
  output logic [15:0]          o_burst_cnt,
  output logic                 o_tout_flush
);

  localparam int unsigned CNT_WDTH = ADDR_WDTH + 1;
  localparam logic [CNT_WDTH-1:0] DPTH_C = CNT_WDTH'(DPTH);

  burst_state_e             state_q, state_d;
  logic [CNT_WDTH-1:0]      rem_q, rem_d;
  logic [CNT_WDTH-1:0]      eff_len;
  logic                     fifo_rd;
  logic [SKID_CNT_WDTH-1:0] skid_cnt;
  logic [DATA_WDTH:0]       skid_rdata;
  logic                     skid_valid;

`ifdef CMIP_BURST_RD_TOUT_EN
  logic [TOUT_WDTH-1:0] tout_cnt_q, tout_cnt_d;
  logic                 tout_flush_q, tout_flush_d;
`else
  logic                 tout_th_unused;
  assign tout_th_unused = ^i_tout_th;
`endif

  // Effective burst length: zero means one beat, never more than the FIFO.
  always_comb begin
    eff_len = i_burst_len;
    if (i_burst_len > DPTH_C) eff_len = DPTH_C;
    if (i_burst_len == '0)    eff_len = CNT_WDTH'(1);
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      rem_q        <= '0;
`ifdef CMIP_BURST_RD_TOUT_EN
      tout_cnt_q   <= '0;
      tout_flush_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
`ifdef CMIP_BURST_RD_TOUT_EN
      tout_cnt_q   <= tout_cnt_d;
      tout_flush_q <= tout_flush_d;
`endif
    end
  end

  // Next state, remaining-beat count and upstream pop (independent of i_ready).
  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
`ifdef CMIP_BURST_RD_TOUT_EN
    tout_cnt_d   = '0;
    tout_flush_d = 1'b0;
`endif
    fifo_rd = (state_q == ST_SEND) && (rem_q != '0) && !i_fifo_empty &&
              (skid_cnt < SKID_CNT_WDTH'(SKID_DPTH));
    case (state_q)
      ST_IDLE: begin
        if (i_fifo_used_cnt >= eff_len) begin
          state_d = ST_SEND;
          rem_d   = eff_len;
        end
`ifdef CMIP_BURST_RD_TOUT_EN
        else if (!i_fifo_empty) begin
          // Counter value reaching the threshold this edge starts a partial burst.
          if ((i_tout_th != '0) &&
              ((TOUT_WDTH+1)'(tout_cnt_q) + (TOUT_WDTH+1)'(1) >= (TOUT_WDTH+1)'(i_tout_th))) begin
            state_d      = ST_SEND;
            rem_d        = (i_fifo_used_cnt == '0) ? CNT_WDTH'(1) : i_fifo_used_cnt;
            tout_flush_d = 1'b1;
          end else begin
            tout_cnt_d = tout_cnt_q + TOUT_WDTH'(1);
          end
        end
`endif
      end
      ST_SEND: begin
        if (fifo_rd) begin
          rem_d = rem_q - CNT_WDTH'(1);
          if (rem_q == CNT_WDTH'(1)) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  cmip_skid_buf #(
    .WDTH (DATA_WDTH + 1)
  ) u_skid (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (fifo_rd),
    .i_wdata ({(rem_q == CNT_WDTH'(1)), i_fifo_dout}),
    .i_ready (i_ready),
    .o_valid (skid_valid),
    .o_rdata (skid_rdata),
    .o_cnt   (skid_cnt)
  );

  // Completed-burst counter, advanced when the tagged beat is accepted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_burst_cnt <= '0;
    end else if (skid_valid && i_ready && skid_rdata[DATA_WDTH]) begin
      o_burst_cnt <= o_burst_cnt + 16'd1;
    end
  end

  assign o_fifo_rd = fifo_rd;
  assign o_valid   = skid_valid;
  assign o_data    = skid_rdata[DATA_WDTH-1:0];
  assign o_last    = skid_rdata[DATA_WDTH];
  assign o_busy    = (state_q != ST_IDLE) || (skid_cnt != '0);

`ifdef CMIP_BURST_RD_TOUT_EN
  assign o_tout_flush = tout_flush_q;
`else
  assign o_tout_flush = 1'b0;
`endif

endmodule

// File: tb/tb_cmip_fifo_burst_reader.sv
// Bench for cmip_fifo_burst_reader: a queue-based FWFT FIFO model feeds the
// DUT and an expected-beat list (words in push order, last tag every
// eff_len words) is compared with the beats accepted downstream.
module tb_cmip_fifo_burst_reader;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 3;
  localparam int unsigned DP = 8;

  logic          i_clk;
  logic          i_rst_n;
  logic [AW:0]   i_burst_len;
  logic [15:0]   i_tout_th;
  logic          i_fifo_empty;
  logic [DW-1:0] i_fifo_dout;
  logic [AW:0]   i_fifo_used_cnt;
  logic          o_fifo_rd;
  logic          o_valid;
  logic [DW-1:0] o_data;
  logic          o_last;
  logic          i_ready;
  logic          o_busy;
  logic [15:0]   o_burst_cnt;
  logic          o_tout_flush;

  cmip_fifo_burst_reader #(
    .DATA_WDTH (DW),
    .ADDR_WDTH (AW),
    .DPTH      (DP)
  ) dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_burst_len     (i_burst_len),
    .i_tout_th       (i_tout_th),
    .i_fifo_empty    (i_fifo_empty),
    .i_fifo_dout     (i_fifo_dout),
    .i_fifo_used_cnt (i_fifo_used_cnt),
    .o_fifo_rd       (o_fifo_rd),
    .o_valid         (o_valid),
    .o_data          (o_data),
    .o_last          (o_last),
    .i_ready         (i_ready),
    .o_busy          (o_busy),
    .o_burst_cnt     (o_burst_cnt),
    .o_tout_flush    (o_tout_flush)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [DW-1:0] fifo_q[$];   // upstream FIFO contents
  logic [DW-1:0] pend_q[$];   // words waiting to be pushed upstream
  logic [DW:0]   exp_q[$];    // expected {last,data} beats
  logic [DW:0]   got_q[$];    // accepted {last,data} beats
  int            rd_cyc[$];
  int            acc_cyc[$];
  int            flush_cyc[$];
  logic [15:0]   exp_bursts;
  int            ready_mode;  // 0: held 1, 1: toggle, 2: random
  int            feed_mode;   // 0: fill FIFO, 1: random trickle
  logic          hold_pending;
  logic [DW:0]   held;

  function automatic int eff_of(int len);
    if (len == 0) return 1;
    return (len > int'(DP)) ? int'(DP) : len;
  endfunction

  task automatic drive_fifo();
    i_fifo_empty    = (fifo_q.size() == 0);
    i_fifo_dout     = (fifo_q.size() == 0) ? '0 : fifo_q[0];
    i_fifo_used_cnt = (AW+1)'(fifo_q.size());
  endtask

  task automatic clear_logs();
    got_q.delete(); exp_q.delete(); rd_cyc.delete(); acc_cyc.delete(); flush_cyc.delete();
  endtask

  // Queue n random words; tag every eff-th (and optionally the final one) as last.
  task automatic gen_words(int n, int eff, bit flush_tail);
    logic [DW-1:0] w;
    logic          l;
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      l = (((i + 1) % eff) == 0) || (flush_tail && (i == n - 1));
      pend_q.push_back(w);
      exp_q.push_back({l, w});
      if (l) exp_bursts = exp_bursts + 16'd1;
    end
  endtask

  task automatic feed();
    if (feed_mode == 0) begin
      while (pend_q.size() > 0 && fifo_q.size() < DP) fifo_q.push_back(pend_q.pop_front());
    end else if (pend_q.size() > 0 && fifo_q.size() < DP && $urandom_range(0, 1) == 1) begin
      fifo_q.push_back(pend_q.pop_front());
    end
    drive_fifo();
  endtask

  // One clock: sample at negedge, then update the FIFO model and ready after posedge.
  task automatic cycle();
    logic rd;
    logic acc;
    @(negedge i_clk);
    rd  = o_fifo_rd;
    acc = o_valid && i_ready;
    if (hold_pending) begin
      checks++;
      if (!o_valid || {o_last, o_data} !== held) begin
        errors++;
        $display("FAIL hold_stable cyc=%0d: valid=%0b beat=%h, required valid=1 beat=%h", cyc, o_valid, {o_last, o_data}, held);
      end
    end
    hold_pending = o_valid && !i_ready;
    held         = {o_last, o_data};
    if (rd) begin
      rd_cyc.push_back(cyc);
      checks++;
      if (fifo_q.size() == 0) begin
        errors++;
        $display("FAIL pop_when_empty cyc=%0d: o_fifo_rd=1 with model FIFO empty, required 0", cyc);
      end
    end
    if (acc) begin
      got_q.push_back({o_last, o_data});
      acc_cyc.push_back(cyc);
    end
    if (o_tout_flush) flush_cyc.push_back(cyc);
    @(posedge i_clk);
    #1;
    cyc++;
    if (rd && fifo_q.size() != 0) void'(fifo_q.pop_front());
    case (ready_mode)
      0:       i_ready = 1'b1;
      1:       i_ready = ~i_ready;
      default: i_ready = 1'($urandom_range(0, 1));
    endcase
    drive_fifo();
  endtask

  // Run until every expected beat arrives (bounded), then compare order, tags, count.
  task automatic run_drain(int budget, string name);
    int n;
    n = 0;
    while (got_q.size() < exp_q.size() && n < budget) begin
      cycle();
      feed();
      n++;
    end
    repeat (6) begin
      cycle();
      feed();
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_beat_count: got %0d beats, required %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s_beat%0d: got last=%0b data=%h, required last=%0b data=%h",
                 name, i, got_q[i][DW], got_q[i][DW-1:0], exp_q[i][DW], exp_q[i][DW-1:0]);
      end
    end
    checks++;
    if (o_burst_cnt !== exp_bursts) begin
      errors++;
      $display("FAIL %s_burst_cnt: got %0d, required %0d", name, o_burst_cnt, exp_bursts);
    end
  endtask

  task automatic check_all_zero(string name);
    checks++;
    if ({o_fifo_rd, o_valid, o_last, o_busy, o_tout_flush} !== 5'b0 || o_data !== '0 || o_burst_cnt !== 16'd0) begin
      errors++;
      $display("FAIL %s: rd=%0b valid=%0b last=%0b busy=%0b flush=%0b data=%h cnt=%0d, required all 0",
               name, o_fifo_rd, o_valid, o_last, o_busy, o_tout_flush, o_data, o_burst_cnt);
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b1; i_burst_len = '0; i_tout_th = '0; i_ready = 1'b1;
    ready_mode = 0; feed_mode = 0; hold_pending = 1'b0; held = '0;
    exp_bursts = '0;
    drive_fifo();
    #3 i_rst_n = 1'b0;
    #1 check_all_zero("reset_async");
    repeat (2) @(posedge i_clk);
    #1 check_all_zero("reset_held");
    i_rst_n = 1'b1;
  endtask

  task automatic test_single_burst();
    clear_logs();
    i_burst_len = 4; ready_mode = 0; i_ready = 1'b1; feed_mode = 0;
    gen_words(4, 4, 1'b0);
    feed();
    run_drain(100, "single");
    checks++;
    if (rd_cyc.size() != 4 || acc_cyc.size() != 4) begin
      errors++;
      $display("FAIL single_counts: reads=%0d accepts=%0d, required 4 and 4", rd_cyc.size(), acc_cyc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (acc_cyc[i] != rd_cyc[0] + 1 + i) begin
          errors++;
          $display("FAIL single_timing beat%0d: at cycle %0d, required %0d", i, acc_cyc[i], rd_cyc[0] + 1 + i);
        end
      end
    end
  endtask

  task automatic test_toggle_ready();
    clear_logs();
    i_burst_len = 4; ready_mode = 1; feed_mode = 0;
    gen_words(8, 4, 1'b0);
    feed();
    run_drain(200, "toggle");
  endtask

  task automatic test_len_bounds();
    clear_logs();
    i_burst_len = 0; ready_mode = 0; i_ready = 1'b1; feed_mode = 0;
    gen_words(3, eff_of(0), 1'b0);
    feed();
    run_drain(100, "len0");
    clear_logs();
    i_burst_len = 15;
    gen_words(8, eff_of(15), 1'b0);
    feed();
    run_drain(100, "len15");
  endtask

  task automatic test_random();
    int len;
    for (int it = 0; it < 6; it++) begin
      clear_logs();
      len = int'($urandom_range(0, 15));
      i_burst_len = (AW+1)'(len);
      ready_mode = 2; feed_mode = 1;
      gen_words(eff_of(len) * int'($urandom_range(1, 3)), eff_of(len), 1'b0);
      run_drain(2000, "random");
    end
    ready_mode = 0; i_ready = 1'b1;
  endtask

`ifdef CMIP_BURST_RD_TOUT_EN
  task automatic test_timeout_flush();
    int c0;
    clear_logs();
    i_burst_len = 4; i_tout_th = 10; ready_mode = 0; i_ready = 1'b1; feed_mode = 0;
    gen_words(2, 4, 1'b1);
    feed();
    c0 = cyc;
    run_drain(100, "tout");
    checks++;
    if (flush_cyc.size() != 1) begin
      errors++;
      $display("FAIL tout_pulses: got %0d flush pulses, required 1", flush_cyc.size());
    end else begin
      checks++;
      if (flush_cyc[0] != c0 + 10) begin
        errors++;
        $display("FAIL tout_delay: flush %0d cycles after non-empty, required 10", flush_cyc[0] - c0);
      end
    end
    i_tout_th = 0;
  endtask
`else
  task automatic test_no_timeout();
    clear_logs();
    i_burst_len = 4; i_tout_th = 10; ready_mode = 0; i_ready = 1'b1; feed_mode = 0;
    gen_words(4, 4, 1'b0);
    fifo_q.push_back(pend_q.pop_front());
    fifo_q.push_back(pend_q.pop_front());
    drive_fifo();
    repeat (100) cycle();
    checks++;
    if (acc_cyc.size() != 0 || rd_cyc.size() != 0 || flush_cyc.size() != 0) begin
      errors++;
      $display("FAIL notout_quiet: accepts=%0d reads=%0d flushes=%0d, required 0 0 0",
               acc_cyc.size(), rd_cyc.size(), flush_cyc.size());
    end
    feed();
    run_drain(100, "notout");
    i_tout_th = 0;
  endtask
`endif

  task automatic test_reset_mid_burst();
    int n;
    clear_logs();
    i_burst_len = 4; ready_mode = 0; i_ready = 1'b1; feed_mode = 0;
    gen_words(4, 4, 1'b0);
    feed();
    n = 0;
    while (got_q.size() < 2 && n < 50) begin
      cycle();
      n++;
    end
    checks++;
    if (got_q.size() < 2) begin
      errors++;
      $display("FAIL rstmid_reach: got %0d beats before reset, required 2", got_q.size());
    end
    i_rst_n = 1'b0;
    #1 check_all_zero("rstmid_outputs");
    fifo_q.delete(); pend_q.delete();
    exp_bursts = '0; hold_pending = 1'b0;
    drive_fifo();
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    #1 check_all_zero("rstmid_release");
    clear_logs();
    gen_words(4, 4, 1'b0);
    feed();
    run_drain(100, "after_rst");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_burst();
    test_toggle_ready();
    test_len_bounds();
`ifdef CMIP_BURST_RD_TOUT_EN
    test_timeout_flush();
`else
    test_no_timeout();
`endif
    test_random();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
